// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch-stage next-PC logic.
//   OP_BEQ    : primary opcode of beq (instruction bits [31:26]).
//   PC_W      : width of the alternate-PC field carried with each branch.
//   PERF_W    : width of the optional performance counters.
//   br_meta_t : per-instruction branch metadata {valid, pred, alt}.
package fetch_pkg;

    localparam logic [5:0]  OP_BEQ = 6'd4;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned PERF_W = 16;

    typedef struct packed {
        logic            valid;  // instruction in this slot is a beq
        logic            pred;   // fetch followed the taken path
        logic [PC_W-1:0] alt;    // PC of the path not followed
    } br_meta_t;

endpackage

// File: rtl/branch_meta_pipe.sv
// branch_meta_pipe: two-stage (ID, EX) shift register for branch metadata.
//   clk, rst_n : clock, asynchronous active-low reset (all slots invalid).
//   stall      : hold the ID slot and insert an invalid bubble into EX.
//   kill       : invalidate both slots at the next edge; wins over stall.
//   meta_in    : metadata produced in IF this cycle.
//   meta_d     : metadata of the instruction in ID.
//   meta_e     : metadata of the instruction in EX.
module branch_meta_pipe
    import fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     stall,
    input  logic     kill,
    input  br_meta_t meta_in,
    output br_meta_t meta_d,
    output br_meta_t meta_e
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_d <= '0;
            meta_e <= '0;
        end else if (kill) begin
            // Both younger slots hold wrong-path instructions; only the valid
            // bit matters, so the payload is left as-is.
            meta_d.valid <= 1'b0;
            meta_e.valid <= 1'b0;
        end else if (stall) begin
            meta_e.valid <= 1'b0;
        end else begin
            meta_d <= meta_in;
            meta_e <= meta_d;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-stage next-PC generator with beq prediction and
// mispredict recovery for a 5-stage MIPS pipeline.
//   clk, rst_n    : clock, asynchronous active-low reset.
//   iInstruction  : instruction fetched at oPC.
//   iPredTaken    : predictor taken bit for the IF instruction.
//   iStall        : load-use stall (hold IF/ID, bubble into EX).
//   iBranch_regE  : EX-stage instruction is beq.
//   izero_regE    : EX-stage ALU zero flag.
//   oPC           : current fetch address (registered).
//   oFlush        : kill IF/ID and ID/EX contents this cycle.
//   oMispredict   : EX beq resolved opposite to its prediction.
//   oBrCount      : resolved-branch counter (saturating).
//   oMissCount    : mispredict counter (saturating).
// Build option: define FETCH_PERF_CNT_EN to build the counters; otherwise
// oBrCount and oMissCount read as zero.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       iInstruction,
    input  logic              iPredTaken,
    input  logic              iStall,
    input  logic              iBranch_regE,
    input  logic              izero_regE,
    output logic [ADDR_W-1:0] oPC,
    output logic              oFlush,
    output logic              oMispredict,
    output logic [15:0]       oBrCount,
    output logic [15:0]       oMissCount
);

    logic              beq_if;
    logic              pred_taken;
    logic [17:0]       imm_sh;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_next;
    logic              actual;
    logic              resolved;
    br_meta_t          meta_if;
    br_meta_t          meta_d;
    br_meta_t          meta_e;

    // IF decode and target computation (all modulo 2^ADDR_W)
    always_comb begin
        beq_if     = (iInstruction[31:26] == OP_BEQ);
        pred_taken = beq_if & iPredTaken;
        imm_sh     = {iInstruction[15:0], 2'b00};
        offset     = ADDR_W'($signed(imm_sh));
        pc4        = oPC + ADDR_W'(4);
        target     = pc4 + offset;
    end

    always_comb begin
        meta_if       = '0;
        meta_if.valid = beq_if;
        meta_if.pred  = pred_taken;
        meta_if.alt   = PC_W'(pred_taken ? pc4 : target);
    end

    branch_meta_pipe u_meta_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (iStall),
        .kill    (oMispredict),
        .meta_in (meta_if),
        .meta_d  (meta_d),
        .meta_e  (meta_e)
    );

    // EX resolution; an untracked beq in EX is never a mispredict
    always_comb begin
        actual      = iBranch_regE & izero_regE;
        resolved    = iBranch_regE & meta_e.valid;
        oMispredict = resolved & (meta_e.pred != actual);
        oFlush      = oMispredict;
    end

    always_comb begin
        pc_next = pc4;
        if (oMispredict) begin
            pc_next = ADDR_W'(meta_e.alt);
        end else if (iStall) begin
            pc_next = oPC;
        end else if (pred_taken) begin
            pc_next = target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oPC <= RESET_PC;
        end else begin
            oPC <= pc_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [PERF_W-1:0] br_cnt;
    logic [PERF_W-1:0] miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else begin
            if (resolved && (br_cnt != '1)) begin
                br_cnt <= br_cnt + PERF_W'(1);
            end
            if (oMispredict && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + PERF_W'(1);
            end
        end
    end

    assign oBrCount   = br_cnt;
    assign oMissCount = miss_cnt;
`else
    assign oBrCount   = '0;
    assign oMissCount = '0;
`endif

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage next-PC generator for the 5-stage MIPS pipeline, sitting directly upstream of the 2-bit beq predictor. It holds the PC register, decodes beq in IF, and redirects fetch to the branch target when the predictor says taken. It carries the prediction and the alternate PC through ID to EX. On a mispredict it restores the correct path and asserts a one-cycle flush.

## Interface
- ADDR_W, 32, PC width in bits.
- RESET_PC, 0, PC value loaded at reset.

- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- iInstruction  in  32  instruction fetched at oPC (IF stage).
- iPredTaken  in  1  predictor taken bit for the current IF instruction.
- iStall  in  1  load-use stall: hold IF and ID, insert a bubble into EX.
- iBranch_regE  in  1  EX-stage instruction is beq.
- izero_regE  in  1  EX-stage ALU zero flag.
- oPC  out  ADDR_W  current fetch address.
- oFlush  out  1  kill the IF/ID and ID/EX contents this cycle.
- oMispredict  out  1  EX-stage beq resolved opposite to its prediction.
- oBrCount  out  16  resolved-branch counter (see Configuration).
- oMissCount  out  16  mispredict counter (see Configuration).

## Operation
- IF decode: beq_if = (iInstruction[31:26] == OP_BEQ).
  - pc4 = oPC + 4.
  - target = pc4 + (sign-extended iInstruction[15:0] << 2).
  - All PC arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Predict-taken condition: beq_if & iPredTaken.
- IF metadata created each cycle: {valid = beq_if, pred = predict-taken condition, alt}.
  - alt = pc4 when pred = 1.
  - alt = target when pred = 0.
- Metadata moves IF→ID→EX in step with the pipeline registers.
- Resolution in EX:
  - actual = iBranch_regE & izero_regE.
  - oMispredict = iBranch_regE & metaE.valid & (metaE.pred != actual).
  - oFlush = oMispredict.
- Next-PC priority, highest first:
  1. oMispredict → metaE.alt.
  2. iStall → hold oPC.
  3. Predict-taken condition → target.
  4. Otherwise → pc4.
- Metadata on a mispredict: ID and EX metadata become invalid at the next edge (wrong-path kill). This overrides iStall.
- Metadata on a stall without a mispredict:
  - ID metadata holds.
  - EX metadata becomes invalid (bubble).
- iBranch_regE with metaE.valid = 0: treated as not mispredicted; no flush.

## Timing
- Reset values: oPC = RESET_PC; all metadata invalid; oFlush = 0; oMispredict = 0; counters = 0.
- oPC is registered; the new fetch address is visible one cycle after the decision.
- oFlush and oMispredict are combinational from the EX metadata and EX inputs, in the same cycle as resolution. They are high for exactly one cycle per mispredicted branch.
- Mispredict penalty: 2 cycles (the IF and ID wrong-path instructions).
- Predicted-taken redirect: 1 cycle, with no bubble.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). No flush is emitted.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - oBrCount increments on every cycle with iBranch_regE & metaE.valid.
  - oMissCount increments on every cycle with oMispredict.
  - Both are 16-bit and saturate at 0xFFFF.
- FETCH_PERF_CNT_EN undefined: both ports are tied to 0 and no counter registers are built.

## Structure
- Shared package fetch_pkg:
  - OP_BEQ = 6'd4.
  - Typedef br_meta_t {valid, pred, alt[ADDR_W-1:0]}.
  - Counter width constant PERF_W = 16.
- Sub-module branch_meta_pipe:
  - Two-stage br_meta_t shift register.
  - Inputs: stall and kill.
  - Outputs: metaD and metaE.
- Top level keeps PC register, decode, next-PC mux and counters.

## Test plan
- Reset, then free run with no branches → oPC = 0x0, 0x4, 0x8, 0xC on successive cycles; oFlush stays 0.
- beq at 0x10, imm = 3, iPredTaken = 1 → next oPC = 0x20.
  - Two cycles later in EX: iBranch_regE = 1, izero_regE = 0.
  - Response: oFlush = 1 for one cycle; next oPC = 0x14.
- beq at 0x10, imm = 0xFFFE, iPredTaken = 0 → fetch continues 0x14, 0x18.
  - Resolved taken in EX → oFlush = 1; next oPC = 0x0C.
- iStall high for 2 cycles at oPC = 0x8 → oPC holds 0x8 both cycles.
  - ID metadata unchanged; EX sees an invalid bubble; no flush.
- Mispredict in EX while iStall = 1 → redirect wins: oFlush = 1, oPC = metaE.alt, ID metadata invalidated.
- With FETCH_PERF_CNT_EN:
  - 3 resolved branches with 1 mispredict → oBrCount = 3, oMissCount = 1.
  - Counter preset near 0xFFFF → oBrCount stays at 0xFFFF after further branches.
